rvc_asap_mem_arb: RTL and testbench

//  Shares one single-port synchronous memory among 3 requesters:
//  0 = core fetch (read-only), 1 = core load/store, 2 = external loader/debug.
//  The external port is the front-door path that writes program/data images.

---
 rtl/rvc_asap_mem_arb_if.sv | 46 ++++
 rtl/rvc_asap_mem_arb.sv | 166 ++++++++++++++++
 tb/tb_rvc_asap_mem_arb.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rvc_asap_mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : rvc_asap_mem_arb_if
// Purpose  : Bundles the three requester ports, the external lock, and the
//            single-port memory command/response signals of rvc_asap_mem_arb.
// Modports : master - requester + memory side (drives req/payload/ext_lock and
//                     mem_rd_data; observes grants, responses, memory command)
//            slave  - the arbiter itself
// Revision : 1.0 - initial release
// ============================================================================
interface rvc_asap_mem_arb_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Requester side: index 0 = core fetch, 1 = core load/store, 2 = external
    logic [2:0]                   req;
    logic [2:0][ADDR_W-1:0]       addr;
    logic [2:0]                   wr_en;
    logic [2:0][DATA_W/8-1:0]     byte_en;
    logic [2:0][DATA_W-1:0]       wr_data;
    logic                         ext_lock;
    logic [2:0]                   gnt;
    logic [2:0]                   rsp_valid;
    logic [DATA_W-1:0]            rsp_data;

    // Memory side
    logic                         mem_cs;
    logic                         mem_we;
    logic [DATA_W/8-1:0]          mem_be;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wr_data;
    logic [DATA_W-1:0]            mem_rd_data;

    modport master (
        output req, addr, wr_en, byte_en, wr_data, ext_lock, mem_rd_data,
        input  gnt, rsp_valid, rsp_data,
        input  mem_cs, mem_we, mem_be, mem_addr, mem_wr_data
    );

    modport slave (
        input  req, addr, wr_en, byte_en, wr_data, ext_lock, mem_rd_data,
        output gnt, rsp_valid, rsp_data,
        output mem_cs, mem_we, mem_be, mem_addr, mem_wr_data
    );
endinterface
`default_nettype wire

// File: rtl/rvc_asap_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : rvc_asap_mem_arb
// Purpose  : Shares one single-port synchronous memory among three requesters
//            (0 = core fetch, 1 = core load/store, 2 = external loader/debug).
//            One combinational one-hot grant per cycle, registered memory
//            command one cycle later, response pulse two cycles after grant.
//            Starvation guard for requesters 0/1; requester 2 can lock the
//            memory for atomic image loading.
// Ports    : clk  - clock
//            rst  - asynchronous active-high reset
//            bus  - rvc_asap_mem_arb_if.slave (requests, grants, responses,
//                   memory command and read data)
// Revision : 1.0 - initial release
// ============================================================================
module rvc_asap_mem_arb #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    rvc_asap_mem_arb_if.slave   bus
);

    localparam int              CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam int              BE_W      = DATA_W / 8;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt0;
    logic [CNT_W-1:0]    r_cnt1;

    // Stage 1: memory command, plus who it belongs to
    logic                r_mem_cs;
    logic                r_mem_we;
    logic [BE_W-1:0]     r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wr_data;
    logic [2:0]          r_issue;

    // Stage 2: response pulse
    logic [2:0]          r_rsp_valid;
    logic                r_rsp_wr;

    logic                w_lock_hold;
    logic                w_starve0;
    logic                w_starve1;
    logic [2:0]          w_gnt;
    logic [1:0]          w_sel;
    logic                w_wr;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    always_comb begin
        // The lock only holds while ext_lock stays high; the first cycle it
        // drops, arbitration is already open.
        w_lock_hold = (r_state == ST_LOCKED) && bus.ext_lock;

        // A saturated counter only counts while the request is still present.
        w_starve0   = bus.req[0] && (r_cnt0 == C_CNT_MAX);
        w_starve1   = bus.req[1] && (r_cnt1 == C_CNT_MAX);

        w_gnt = 3'b000;
        if (w_lock_hold) begin
            w_gnt[2] = bus.req[2];
        end else if (w_starve0) begin
            w_gnt = 3'b001;
        end else if (w_starve1) begin
            w_gnt = 3'b010;
        end else if (bus.req[2]) begin
            w_gnt = 3'b100;
        end else if (bus.req[1]) begin
            w_gnt = 3'b010;
        end else if (bus.req[0]) begin
            w_gnt = 3'b001;
        end

        w_sel = w_gnt[2] ? 2'd2 : (w_gnt[1] ? 2'd1 : 2'd0);

        // Fetch port is read-only regardless of its wr_en bit.
        w_wr  = (|w_gnt) && (w_sel != 2'd0) && bus.wr_en[w_sel];
    end

    // ------------------------------------------------------------------------
    // State, starvation counters, command and response pipeline
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_OPEN;
            r_cnt0        <= '0;
            r_cnt1        <= '0;
            r_mem_cs      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_be      <= '0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= '0;
            r_issue       <= '0;
            r_rsp_valid   <= '0;
            r_rsp_wr      <= 1'b0;
        end else begin
            case (r_state)
                ST_OPEN: begin
                    if (w_gnt[2] && bus.ext_lock) begin
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!bus.ext_lock) begin
                        r_state <= ST_OPEN;
                    end
                end
                default: r_state <= ST_OPEN;
            endcase

            // Counters freeze while the external port holds the lock.
            if (!w_lock_hold) begin
                if (!bus.req[0] || w_gnt[0]) begin
                    r_cnt0 <= '0;
                end else if (r_cnt0 != C_CNT_MAX) begin
                    r_cnt0 <= r_cnt0 + 1'b1;
                end

                if (!bus.req[1] || w_gnt[1]) begin
                    r_cnt1 <= '0;
                end else if (r_cnt1 != C_CNT_MAX) begin
                    r_cnt1 <= r_cnt1 + 1'b1;
                end
            end

            // Idle cycles drive an all-zero command so nothing stale leaks
            // onto the memory pins.
            r_mem_cs      <= |w_gnt;
            r_mem_we      <= w_wr;
            r_mem_be      <= w_wr ? bus.byte_en[w_sel] : '0;
            r_mem_addr    <= (|w_gnt) ? bus.addr[w_sel] : '0;
            r_mem_wr_data <= w_wr ? bus.wr_data[w_sel] : '0;
            r_issue       <= w_gnt;

            r_rsp_valid   <= r_issue;
            r_rsp_wr      <= r_mem_we;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.gnt         = w_gnt;
    assign bus.mem_cs      = r_mem_cs;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_be      = r_mem_be;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wr_data = r_mem_wr_data;
    assign bus.rsp_valid   = r_rsp_valid;
    // Read data comes straight from the memory in the response cycle;
    // write acknowledgements carry zero.
    assign bus.rsp_data    = ((|r_rsp_valid) && !r_rsp_wr) ? bus.mem_rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_rvc_asap_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvc_asap_mem_arb
// Purpose  : Self-checking bench for rvc_asap_mem_arb with a behavioural
//            single-port memory and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvc_asap_mem_arb;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int WORDS        = 1 << (ADDR_W - 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rvc_asap_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rvc_asap_mem_arb #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;
    exp_t sb_q[$];

    logic [31:0] mem_arr [WORDS];
    logic [31:0] ref_mem [WORDS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] preload(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'h1000_0000 + 32'(i));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem_arr[i] <= preload(i);
            bus.mem_rd_data <= '0;
        end else if (bus.mem_cs) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b])
                        mem_arr[bus.mem_addr[ADDR_W-1:2]][8*b +: 8] <= bus.mem_wr_data[8*b +: 8];
            end
            bus.mem_rd_data <= mem_arr[bus.mem_addr[ADDR_W-1:2]];
        end
    end

    // Scoreboard: predict at grant, compare at response.
    int          mon_sel;
    int          mon_word;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            for (int i = 0; i < WORDS; i++) ref_mem[i] = preload(i);
        end else begin
            if (bus.rsp_valid != 3'b000) begin
                check("rsp_onehot", 64'($onehot(bus.rsp_valid)), 64'd1);
                if (sb_q.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_idx",  64'(bus.rsp_valid), 64'(mon_e.idx));
                    check("rsp_data", 64'(bus.rsp_data),  64'(mon_e.data));
                    check("rsp_lat",  64'(cyc),           64'(mon_e.cyc));
                end
            end
            if (bus.gnt != 3'b000) begin
                check("gnt_onehot",      64'($onehot(bus.gnt)), 64'd1);
                check("gnt_without_req", 64'(bus.gnt & ~bus.req), 64'd0);
                mon_sel  = bus.gnt[2] ? 2 : (bus.gnt[1] ? 1 : 0);
                mon_word = int'(bus.addr[mon_sel][ADDR_W-1:2]);
                mon_e.idx = bus.gnt;
                mon_e.cyc = cyc + 2;
                if (mon_sel != 0 && bus.wr_en[mon_sel]) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.byte_en[mon_sel][b])
                            ref_mem[mon_word][8*b +: 8] = bus.wr_data[mon_sel][8*b +: 8];
                    mon_e.data = 32'h0;
                end else begin
                    mon_e.data = ref_mem[mon_word];
                end
                sb_q.push_back(mon_e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] g;

    initial begin
        bus.req      = 3'b000;
        bus.addr     = '0;
        bus.wr_en    = 3'b000;
        bus.byte_en  = '0;
        bus.wr_data  = '0;
        bus.ext_lock = 1'b0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_mem_cs",    64'(bus.mem_cs),    64'd0);
        check("rst_mem_we",    64'(bus.mem_we),    64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        rst = 1'b0;

        // 1: single fetch read of preloaded word
        tick();
        bus.addr[0] = 10'h010;
        bus.req     = 3'b001;
        @(negedge clk);
        check("t1_gnt", 64'(bus.gnt), 64'b001);
        tick();
        bus.req = 3'b000;
        @(negedge clk);
        check("t1_mem_cs",   64'(bus.mem_cs),   64'd1);
        check("t1_mem_addr", 64'(bus.mem_addr), 64'h10);
        check("t1_mem_we",   64'(bus.mem_we),   64'd0);
        tick();
        @(negedge clk);
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'b001);
        check("t1_rsp_data",  64'(bus.rsp_data),  64'hDEAD_BEEF);
        tick();
        @(negedge clk);
        check("t1_idle_cs", 64'(bus.mem_cs), 64'd0);

        // 2: simultaneous requests -> 2, 1, 0
        tick();
        bus.addr[1] = 10'h020;
        bus.addr[2] = 10'h030;
        bus.req     = 3'b111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            g = bus.gnt;
            check("t2_gnt", 64'(g), 64'(3'b100 >> k));
            tick();
            bus.req = bus.req & ~g;
        end
        repeat (3) tick();

        // 3: requester 1 starved behind requester 2
        bus.req = 3'b110;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t3_gnt", 64'(bus.gnt), (k == 4 || k == 9) ? 64'b010 : 64'b100);
            tick();
        end
        bus.req = 3'b000;
        repeat (3) tick();

        // 4: locked external byte write while fetch waits
        bus.addr[2]    = 10'h010;
        bus.wr_en[2]   = 1'b1;
        bus.byte_en[2] = 4'b0001;
        bus.wr_data[2] = 32'h0000_00A5;
        bus.ext_lock   = 1'b1;
        bus.addr[0]    = 10'h010;
        bus.req        = 3'b101;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t4_gnt_locked", 64'(bus.gnt), 64'b100);
            if (k == 1) begin
                check("t4_mem_we", 64'(bus.mem_we), 64'd1);
                check("t4_mem_be", 64'(bus.mem_be), 64'b0001);
            end
            tick();
        end
        bus.ext_lock = 1'b0;
        bus.wr_en[2] = 1'b0;
        bus.req      = 3'b001;
        @(negedge clk);
        check("t4_gnt_unlock", 64'(bus.gnt), 64'b001);
        tick();
        bus.req = 3'b000;
        repeat (3) tick();

        // 5: reset one cycle after a read grant
        bus.addr[0] = 10'h020;
        bus.req     = 3'b001;
        @(negedge clk);
        check("t5_gnt", 64'(bus.gnt), 64'b001);
        tick();
        bus.req = 3'b000;
        rst     = 1'b1;
        @(negedge clk);
        check("t5_mem_cs",     64'(bus.mem_cs),    64'd0);
        check("t5_mem_addr",   64'(bus.mem_addr),  64'd0);
        check("t5_rsp_valid",  64'(bus.rsp_valid), 64'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_no_rsp", 64'(bus.rsp_valid), 64'd0);
            tick();
        end
        bus.addr[0] = 10'h010;
        bus.req     = 3'b001;
        @(negedge clk);
        check("t5_regrant", 64'(bus.gnt), 64'b001);
        tick();
        bus.req = 3'b000;
        repeat (4) tick();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
